// File: rtl/dma_responder.sv
// dma_responder: stand-alone responder for the per-device DMA handshake.
// Serves one request at a time from a local byte RAM and inserts
// WAIT_CYCLES wait states between the accept and the memory access.
//
// Ports:
//   clk, rst_n       system clock, async active-low reset
//   req              transfer request (level)
//   rnw              1 = read, 0 = write (captured on accept)
//   addr[20:0]       byte address; only addr[AW-1:0] used (upper bits alias)
//   wd[7:0]          write data (captured on accept)
//   rd[7:0]          read data, updated on a read's done edge and held
//   ack              one-cycle pulse: request accepted
//   done             one-cycle pulse: transfer completed
//   busy             high from accept until the done edge
//   xfer_cnt[15:0]   completed-transfer counter (wraps)
//   bd_we/bd_addr/bd_wd  backdoor RAM write port for preload
module dma_responder #(
  parameter int unsigned AW          = 10,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req,
  input  logic          rnw,
  input  logic [20:0]   addr,
  input  logic [7:0]    wd,
  output logic [7:0]    rd,
  output logic          ack,
  output logic          done,
  output logic          busy,
  output logic [15:0]   xfer_cnt,
  input  logic          bd_we,
  input  logic [AW-1:0] bd_addr,
  input  logic [7:0]    bd_wd
);

  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned CW    = 4;
  localparam int unsigned DW    = 8;
  localparam int unsigned XW    = 16;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_wait_cnt;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wd;
  logic            r_rnw;
  logic            r_ack;
  logic            r_done;
  logic            r_busy;
  logic [DW-1:0]   r_rd;
  logic [XW-1:0]   r_xfer_cnt;
  logic [DW-1:0]   r_mem [DEPTH];

  state_t          w_nxt_state;
  logic [CW-1:0]   w_nxt_wait_cnt;
  logic            w_nxt_ack;
  logic            w_nxt_done;
  logic            w_nxt_busy;
  logic            w_accept;
  logic            w_access;

  // Upper address bits alias onto the RAM and are intentionally ignored.
  if (AW < 21) begin : g_alias
    logic w_unused_addr_hi;
    assign w_unused_addr_hi = ^addr[20:AW];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nxt_state;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_nxt_state    = r_state;
    w_nxt_wait_cnt = r_wait_cnt;
    w_nxt_ack      = 1'b0;
    w_nxt_done     = 1'b0;
    w_nxt_busy     = r_busy;
    w_accept       = 1'b0;
    w_access       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (req) begin
          w_accept       = 1'b1;
          w_nxt_ack      = 1'b1;
          w_nxt_busy     = 1'b1;
          w_nxt_wait_cnt = CW'(WAIT_CYCLES);
          w_nxt_state    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (r_wait_cnt != '0) begin
          w_nxt_wait_cnt = r_wait_cnt - CW'(1);
        end else begin
          w_access    = 1'b1;
          w_nxt_done  = 1'b1;
          w_nxt_busy  = 1'b0;
          w_nxt_state = ST_IDLE;
        end
      end
      default: begin
        w_nxt_state = ST_IDLE;
      end
    endcase
  end

  // Handshake outputs, request capture, read data and transfer counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
      r_addr     <= '0;
      r_wd       <= '0;
      r_rnw      <= 1'b0;
      r_ack      <= 1'b0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
      r_rd       <= '0;
      r_xfer_cnt <= '0;
    end else begin
      r_wait_cnt <= w_nxt_wait_cnt;
      r_ack      <= w_nxt_ack;
      r_done     <= w_nxt_done;
      r_busy     <= w_nxt_busy;
      if (w_accept) begin
        r_addr <= addr[AW-1:0];
        r_wd   <= wd;
        r_rnw  <= rnw;
      end
      if (w_access) begin
        r_xfer_cnt <= r_xfer_cnt + XW'(1);
        // Pre-edge RAM contents: a same-edge backdoor write is not visible.
        if (r_rnw) begin
          r_rd <= r_mem[r_addr];
        end
      end
    end
  end

  // RAM write port; the DMA write is ordered last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (bd_we) begin
      r_mem[bd_addr] <= bd_wd;
    end
    if (w_access && !r_rnw) begin
      r_mem[r_addr] <= r_wd;
    end
  end

  assign rd       = r_rd;
  assign ack      = r_ack;
  assign done     = r_done;
  assign busy     = r_busy;
  assign xfer_cnt = r_xfer_cnt;

endmodule
